// File: rtl/tick_gen_prog.sv
// Runtime-programmable tick generator: main tick every div_reg enabled clocks, cascaded sub_tick
// every sub_reg ticks, periodic or one-shot. Optional square-wave output under TICK_GEN_SQUARE_EN.
module tick_gen_prog #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DIV_DEFAULT = 1000000,
  parameter int unsigned SUB_W       = 8,
  parameter int unsigned SUB_DEFAULT = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             div_ld,
  input  logic [CNT_W-1:0] div_in,
  input  logic             sub_ld,
  input  logic [SUB_W-1:0] sub_in,
  output logic             tick,
  output logic             sub_tick,
  output logic             busy,
`ifdef TICK_GEN_SQUARE_EN
  output logic             sq_out,
`endif
  output logic [CNT_W-1:0] count
);

  typedef enum logic [0:0] {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_div, w_div_nxt;
  logic [SUB_W-1:0]   r_sub, w_sub_nxt;
  logic [SUB_W-1:0]   r_sub_cnt, w_sub_cnt_nxt;
  logic               r_mode_q;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_tick_nxt, w_sub_tick_nxt, w_busy_nxt;
  logic               w_step;
  logic [CNT_W-1:0]   w_div_eff;
  logic [SUB_W-1:0]   w_sub_eff;
  logic               w_term, w_sub_term, w_mode_chg;

  assign w_div_eff  = (r_div == '0) ? CNT_W'(1) : r_div;
  assign w_sub_eff  = (r_sub == '0) ? SUB_W'(1) : r_sub;
  assign w_term     = (count == w_div_eff - CNT_W'(1));
  assign w_sub_term = (r_sub_cnt == w_sub_eff - SUB_W'(1));
  assign w_mode_chg = (mode != r_mode_q);

  // Next-state: loads, then mode change, then start/counting.
  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_sub_nxt      = r_sub;
    w_sub_cnt_nxt  = r_sub_cnt;
    w_count_nxt    = count;
    w_tick_nxt     = 1'b0;
    w_sub_tick_nxt = 1'b0;
    w_busy_nxt     = busy;
    w_step         = 1'b0;

    if (div_ld) begin
      w_div_nxt   = div_in;
      w_count_nxt = '0;
    end
    if (sub_ld) begin
      w_sub_nxt     = sub_in;
      w_sub_cnt_nxt = '0;
    end

    if (w_mode_chg) begin
      w_count_nxt = '0;
      w_busy_nxt  = 1'b0;
      w_state_nxt = IDLE;
    end else if (!div_ld) begin
      if (!mode) begin
        w_busy_nxt  = en;
        w_step      = en;
        w_state_nxt = IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            w_count_nxt = '0;
            if (start) begin
              w_state_nxt = ARMED;
              w_busy_nxt  = 1'b1;
            end
          end
          ARMED: begin
            if (start) w_count_nxt = '0;
            else       w_step      = en;
          end
          default: w_state_nxt = IDLE;
        endcase
      end
    end

    if (w_step) begin
      if (w_term) begin
        w_count_nxt = '0;
        w_tick_nxt  = 1'b1;
        if (mode) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
        // A coincident sub_ld already cleared the sub counter and wins.
        if (!sub_ld) begin
          if (w_sub_term) begin
            w_sub_cnt_nxt  = '0;
            w_sub_tick_nxt = 1'b1;
          end else begin
            w_sub_cnt_nxt = r_sub_cnt + SUB_W'(1);
          end
        end
      end else begin
        w_count_nxt = count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_div     <= CNT_W'(DIV_DEFAULT);
      r_sub     <= SUB_W'(SUB_DEFAULT);
      r_sub_cnt <= '0;
      r_mode_q  <= mode;
      count     <= '0;
      tick      <= 1'b0;
      sub_tick  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_sub     <= w_sub_nxt;
      r_sub_cnt <= w_sub_cnt_nxt;
      r_mode_q  <= mode;
      count     <= w_count_nxt;
      tick      <= w_tick_nxt;
      sub_tick  <= w_sub_tick_nxt;
      busy      <= w_busy_nxt;
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  // Square wave flips on each tick edge; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset)          sq_out <= 1'b0;
    else if (w_tick_nxt) sq_out <= ~sq_out;
  end
`endif

endmodule

// File: tb/tb_tick_gen_prog.sv
// Self-checking bench for tick_gen_prog: directed scenarios plus randomized run against a
// cycle-level arithmetic reference model.
module tb_tick_gen_prog;

  localparam int unsigned CNT_W = 24;
  localparam int unsigned SUB_W = 8;

  logic             clk = 1'b0;
  logic             reset, en, mode, start, div_ld, sub_ld;
  logic [CNT_W-1:0] div_in;
  logic [SUB_W-1:0] sub_in;
  logic             tick, sub_tick, busy;
  logic [CNT_W-1:0] count;
`ifdef TICK_GEN_SQUARE_EN
  logic             sq_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  tick_gen_prog dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start),
    .div_ld(div_ld), .div_in(div_in), .sub_ld(sub_ld), .sub_in(sub_in),
    .tick(tick), .sub_tick(sub_tick), .busy(busy),
`ifdef TICK_GEN_SQUARE_EN
    .sq_out(sq_out),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: counters as modular arithmetic over plain ints.
  int m_div, m_subr, m_cnt, m_subc;
  bit m_tick, m_stick, m_busy, m_armed, m_sq, m_mode_prev;

  task automatic model_edge();
    int  deff, seff;
    bit  adv;
    if (!reset) begin
      m_cnt = 0; m_subc = 0; m_tick = 0; m_stick = 0; m_busy = 0; m_armed = 0;
      m_div = 1000000; m_subr = 100; m_sq = 0; m_mode_prev = mode;
      return;
    end
    m_tick = 0; m_stick = 0; adv = 0;
    if (div_ld) begin m_div = int'(div_in); m_cnt = 0; end
    if (sub_ld) begin m_subr = int'(sub_in); m_subc = 0; end
    if (mode != m_mode_prev) begin
      m_cnt = 0; m_busy = 0; m_armed = 0;
    end else if (!div_ld) begin
      if (!mode) begin m_busy = en; adv = en; end
      else if (start) begin m_armed = 1; m_busy = 1; m_cnt = 0; end
      else adv = m_armed && en;
    end
    if (adv) begin
      deff  = (m_div == 0) ? 1 : m_div;
      m_cnt = (m_cnt + 1) % deff;
      if (m_cnt == 0) begin
        m_tick = 1;
        m_sq   = !m_sq;
        if (mode) begin m_armed = 0; m_busy = 0; end
        if (!sub_ld) begin
          seff    = (m_subr == 0) ? 1 : m_subr;
          m_subc  = (m_subc + 1) % seff;
          m_stick = (m_subc == 0);
        end
      end
    end
    m_mode_prev = mode;
  endtask

  // One clock edge: model sees the same inputs as the DUT, outputs sampled 1ns later.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit saw_tick = 0;
    reset = 0; en = 1; mode = 0; start = 1; div_ld = 0; sub_ld = 0; div_in = '0; sub_in = '0;
    repeat (3) step();
    start = 0;
    n_checks++; if (tick !== 1'b0)     begin n_errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    n_checks++; if (sub_tick !== 1'b0) begin n_errors++; $display("FAIL reset_sub_tick got=%b exp=0", sub_tick); end
    n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (count !== 24'd0)   begin n_errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    reset = 1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (tick === 1'b1 || sub_tick === 1'b1) saw_tick = 1;
    end
    n_checks++; if (saw_tick !== 1'b0) begin n_errors++; $display("FAIL default_no_tick got=%b exp=0", saw_tick); end
    n_checks++; if (count !== 24'd300) begin n_errors++; $display("FAIL default_count got=%0d exp=300", count); end
    n_checks++; if (busy !== 1'b1)     begin n_errors++; $display("FAIL default_busy got=%b exp=1", busy); end
  endtask

  task automatic test_div_sub();
    en = 0; div_ld = 1; div_in = 24'd4; sub_ld = 1; sub_in = 8'd3;
    step();
    div_ld = 0; sub_ld = 0;
    n_checks++; if (count !== 24'd0) begin n_errors++; $display("FAIL divld_count got=%0d exp=0", count); end
    en = 1;
    for (int k = 1; k <= 40; k++) begin
      step();
      n_checks++;
      if (tick !== 1'((k % 4) == 0)) begin n_errors++; $display("FAIL div4_tick k=%0d got=%b", k, tick); end
      n_checks++;
      if (sub_tick !== 1'((k % 12) == 0)) begin n_errors++; $display("FAIL sub3_tick k=%0d got=%b", k, sub_tick); end
      n_checks++;
      if (count !== 24'(k % 4)) begin n_errors++; $display("FAIL div4_count k=%0d got=%0d exp=%0d", k, count, k % 4); end
    end
  endtask

  task automatic test_div_zero();
    en = 1; div_ld = 1; div_in = 24'd0;
    step();
    div_ld = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++; if (tick !== 1'b1) begin n_errors++; $display("FAIL div0_tick k=%0d got=%b exp=1", k, tick); end
    end
    div_ld = 1; div_in = 24'd5;
    step();
    div_ld = 0;
    n_checks++; if (tick !== 1'b0) begin n_errors++; $display("FAIL ld_on_term_tick got=%b exp=0", tick); end
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (tick !== 1'((k % 5) == 0)) begin n_errors++; $display("FAIL div5_tick k=%0d got=%b", k, tick); end
    end
  endtask

  task automatic test_oneshot();
    en = 1; mode = 1; div_ld = 1; div_in = 24'd10;
    step();
    div_ld = 0;
    step();
    n_checks++; if (busy !== 1'b0 || count !== 24'd0) begin n_errors++; $display("FAIL os_idle busy=%b count=%0d exp 0/0", busy, count); end
    start = 1; step(); start = 0;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL os_arm_busy got=%b exp=1", busy); end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++;
      if (tick !== 1'(k == 10)) begin n_errors++; $display("FAIL os_tick k=%0d got=%b", k, tick); end
      n_checks++;
      if (busy !== 1'(k < 10)) begin n_errors++; $display("FAIL os_busy k=%0d got=%b", k, busy); end
    end
    start = 1; step(); start = 0;
    repeat (5) step();
    start = 1; step(); start = 0;
    n_checks++; if (count !== 24'd0 || busy !== 1'b1) begin n_errors++; $display("FAIL os_restart count=%0d busy=%b exp 0/1", count, busy); end
    for (int k = 1; k <= 11; k++) begin
      step();
      n_checks++;
      if (tick !== 1'(k == 10)) begin n_errors++; $display("FAIL os_restart_tick k=%0d got=%b", k, tick); end
    end
  endtask

  task automatic test_en_freeze();
    bit saw_tick = 0;
    en = 1; mode = 0; div_ld = 1; div_in = 24'd8;
    step();
    div_ld = 0;
    repeat (3) step();
    n_checks++; if (count !== 24'd3) begin n_errors++; $display("FAIL pre_freeze_count got=%0d exp=3", count); end
    en = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_checks++;
      if (count !== 24'd3 || tick !== 1'b0) begin n_errors++; $display("FAIL freeze k=%0d count=%0d tick=%b", k, count, tick); end
    end
    en = 1;
    for (int k = 4; k <= 8; k++) begin
      step();
      n_checks++;
      if (tick !== 1'(k == 8)) begin n_errors++; $display("FAIL thaw_tick k=%0d got=%b", k, tick); end
    end
    repeat (3) step();
    reset = 0; step(); reset = 1;
    n_checks++;
    if (tick !== 1'b0 || sub_tick !== 1'b0 || busy !== 1'b0 || count !== 24'd0) begin
      n_errors++; $display("FAIL midreset tick=%b sub=%b busy=%b count=%0d exp all 0", tick, sub_tick, busy, count);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (tick === 1'b1) saw_tick = 1;
    end
    n_checks++; if (saw_tick !== 1'b0 || count !== 24'd20) begin n_errors++; $display("FAIL div_default_restored tick_seen=%b count=%0d exp 0/20", saw_tick, count); end
  endtask

`ifdef TICK_GEN_SQUARE_EN
  task automatic test_square();
    logic s0;
    en = 1; mode = 0; div_ld = 1; div_in = 24'd3;
    step();
    div_ld = 0;
    s0 = sq_out;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++;
      if (sq_out !== (s0 ^ 1'(((k / 3) % 2) == 1))) begin n_errors++; $display("FAIL sq_out k=%0d got=%b", k, sq_out); end
    end
  endtask
`endif

  task automatic test_random();
    div_ld = 1; div_in = 24'd6; sub_ld = 1; sub_in = 8'd2; en = 1;
    step();
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 199) != 0);
      en     = ($urandom_range(0, 7) != 0);
      start  = ($urandom_range(0, 7) == 0);
      div_ld = ($urandom_range(0, 15) == 0);
      div_in = 24'($urandom_range(0, 12));
      sub_ld = ($urandom_range(0, 31) == 0);
      sub_in = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      step();
      n_checks++;
      if (tick !== m_tick || sub_tick !== m_stick || busy !== m_busy || count !== 24'(m_cnt)) begin
        n_errors++;
        $display("FAIL random i=%0d got t=%b s=%b b=%b c=%0d exp t=%b s=%b b=%b c=%0d",
                 i, tick, sub_tick, busy, count, m_tick, m_stick, m_busy, m_cnt);
      end
`ifdef TICK_GEN_SQUARE_EN
      n_checks++;
      if (sq_out !== m_sq) begin n_errors++; $display("FAIL random_sq i=%0d got=%b exp=%b", i, sq_out, m_sq); end
`endif
    end
    reset = 1; div_ld = 0; sub_ld = 0; start = 0;
  endtask

  initial begin
    test_reset();
    test_div_sub();
    test_div_zero();
    test_oneshot();
    test_en_freeze();
`ifdef TICK_GEN_SQUARE_EN
    test_square();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
